// File: rtl/ysyx_23060203_icache_2way.sv
// Two-way set-associative instruction cache with a single-burst AXI4 line refill.
// Latency: hits are combinational; a miss costs 2 + words-per-line cycles minimum.
// Backpressure: AR is held until arready; R beats are consumed only while rvalid.
module ysyx_23060203_icache_2way #(
    parameter int SET_BITS  = 3,
    parameter int LINE_BITS = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        fencei,
    input  logic [31:0] addr,
    output logic        hit,
    output logic [31:0] inst,
    output logic [31:0] araddr,
    output logic        arvalid,
    input  logic        arready,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    input  logic        rvalid,
    output logic        rready,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast
);
    localparam int SETS     = 1 << SET_BITS;
    localparam int WORDS    = 1 << (LINE_BITS - 2);
    localparam int OFF_BITS = LINE_BITS - 2;
    localparam int TAG_LSB  = LINE_BITS + SET_BITS;
    localparam int TAG_BITS = 32 - TAG_LSB;

    typedef enum logic [1:0] {IDLE, AR, R} state_t;
    state_t state, state_nxt;

    logic [SETS-1:0]     valid0, valid1, lru;
    logic [TAG_BITS-1:0] tag0 [SETS];
    logic [TAG_BITS-1:0] tag1 [SETS];
    logic [31:0]         data0 [SETS][WORDS];
    logic [31:0]         data1 [SETS][WORDS];

    logic [31:0]         line_addr;
    logic [SET_BITS-1:0] fill_idx;
    logic                victim;
    logic [OFF_BITS-1:0] cnt;
    logic                err;
    logic                pend;

    logic [OFF_BITS-1:0] off;
    logic [SET_BITS-1:0] idx;
    logic [TAG_BITS-1:0] tag;
    logic                hit0, hit1, lookup, miss_start, victim_sel;
    logic                ar_fire, beat, done, beat_err;
    logic                unused_addr;

    assign off         = addr[LINE_BITS-1:2];
    assign idx         = addr[TAG_LSB-1:LINE_BITS];
    assign tag         = addr[31:TAG_LSB];
    assign unused_addr = ^addr[1:0];

    assign hit0   = valid0[idx] && (tag0[idx] == tag);
    assign hit1   = valid1[idx] && (tag1[idx] == tag);
    assign lookup = hit0 | hit1;

    assign hit  = (state == IDLE) & lookup & ~fencei;
    assign inst = hit1 ? data1[idx][off] : data0[idx][off];

    assign miss_start = (state == IDLE) & ~lookup & ~fencei;
    assign victim_sel = ~valid0[idx] ? 1'b0 : (~valid1[idx] ? 1'b1 : lru[idx]);

    assign ar_fire  = (state == AR) & arready;
    assign beat     = (state == R) & rvalid;
    assign done     = beat & rlast;
    assign beat_err = |rresp;

    assign araddr  = line_addr;
    assign arlen   = 8'(WORDS - 1);
    assign arsize  = 3'b010;
    assign arburst = 2'b01;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        arvalid   = 1'b0;
        rready    = 1'b0;
        case (state)
            IDLE: if (miss_start) state_nxt = AR;
            AR: begin
                arvalid = 1'b1;
                if (arready) state_nxt = R;
            end
            R: begin
                rready = 1'b1;
                if (rvalid && rlast) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            line_addr <= '0;
            fill_idx  <= '0;
            victim    <= 1'b0;
            cnt       <= '0;
            err       <= 1'b0;
            pend      <= 1'b0;
        end else begin
            if (miss_start) begin
                line_addr <= {addr[31:LINE_BITS], {LINE_BITS{1'b0}}};
                fill_idx  <= idx;
                victim    <= victim_sel;
            end
            if (ar_fire) begin
                cnt <= '0;
                err <= 1'b0;
            end
            if (beat) begin
                cnt <= cnt + 1'b1;
                if (beat_err) err <= 1'b1;
            end
            // A fencei seen on the final beat is applied at that same edge, so pend just clears.
            if (done) begin
                err  <= 1'b0;
                pend <= 1'b0;
            end else if ((state != IDLE) && fencei) begin
                pend <= 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid0 <= '0;
            valid1 <= '0;
            lru    <= '0;
        end else if (state == IDLE) begin
            if (fencei) begin
                valid0 <= '0;
                valid1 <= '0;
            end else if (lookup) begin
                lru[idx] <= hit0;
            end
        end else if (done) begin
            if (pend | fencei) begin
                valid0 <= '0;
                valid1 <= '0;
            end else if (victim) begin
                valid1[fill_idx] <= ~(err | beat_err);
            end else begin
                valid0[fill_idx] <= ~(err | beat_err);
            end
            lru[fill_idx] <= ~victim;
        end
    end

    // Payload arrays carry no reset; the valid bits gate every use.
    always_ff @(posedge clock) begin
        if (beat) begin
            if (victim) data1[fill_idx][cnt] <= rdata;
            else        data0[fill_idx][cnt] <= rdata;
        end
        if (done) begin
            if (victim) tag1[fill_idx] <= line_addr[31:TAG_LSB];
            else        tag0[fill_idx] <= line_addr[31:TAG_LSB];
        end
    end
endmodule
